sccb_slave_responder: RTL and testbench

//  Responder (slave) end of the SCCB/I2C camera configuration link. Over-samples i2c_sclk and
//  i2c_sdat on clk_25M and decodes 3-phase writes: device byte, 16-bit register address,

---
 rtl/sccb_slave_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_sccb_slave_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave_responder.sv
// sccb_slave_responder: SCCB/I2C register-port responder used as an OV5640
// stand-in. Decodes device byte, 16-bit register address and a burst of data
// bytes, presenting each data byte as a one-cycle write strobe.
// Optional read support is compiled in with the macro SCCB_RD_EN.
// Ports:
//   clk_25M, camera_rstn   sole clock, async active-low reset
//   i2c_sclk, i2c_sdat     SCCB clock input and open-drain data
//   wr_en/wr_addr/wr_data  write strobe and payload
//   rd_req/rd_addr/rd_data read request and returned byte (SCCB_RD_EN)
//   busy, cmd_cnt          START..STOP flag, saturating write count
module sccb_slave_responder #(
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic        clk_25M,
    input  logic        camera_rstn,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic [8:0]  cmd_cnt
);
    localparam int unsigned HW = 8;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WD, WD_ACK, RD, RD_MACK, IGNORE
    } state_t;

    state_t        state;
    logic [2:0]    scl_s;
    logic [2:0]    sda_s;
    logic          sda_in;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;
    logic [HW-1:0] hold_cnt;
    logic          hold_fire;
    logic          sda_oe;
    logic [7:0]    sh;
    logic [7:0]    byte_in;
    logic [3:0]    bit_cnt;
    logic [15:0]   ptr;
    logic          dev_match;

    // Open-drain: only ever pull low or release.
    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronizer plus a third stage for edge detection; idle bus is high.
    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            scl_s <= 3'b111;
            sda_s <= 3'b111;
        end else begin
            scl_s <= {scl_s[1:0], i2c_sclk};
            sda_s <= {sda_s[1:0], i2c_sdat};
        end
    end

    assign sda_in    = sda_s[1];
    assign scl_rise  = scl_s[1] & ~scl_s[2];
    assign scl_fall  = ~scl_s[1] & scl_s[2];
    assign start_det = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
    assign stop_det  = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
    assign byte_in   = {sh[6:0], sda_in};
    assign dev_match = (sh[7:1] == DEV_ADDR);

    // SDA may only change HOLD_CYC cycles after each synchronized SCL fall.
    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            hold_cnt <= '0;
        end else if (scl_fall) begin
            hold_cnt <= HW'(HOLD_CYC);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    assign hold_fire = (hold_cnt == HW'(1));

`ifdef SCCB_RD_EN
    logic [1:0] rd_dly;
    logic [7:0] tx;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
    assign rd_req  = 1'b0;
    assign rd_addr = 16'd0;
`endif

    // Protocol FSM with registered outputs.
    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= 16'd0;
            wr_data <= 8'd0;
            busy    <= 1'b0;
            cmd_cnt <= 9'd0;
            ptr     <= 16'd0;
            sh      <= 8'd0;
            bit_cnt <= 4'd0;
`ifdef SCCB_RD_EN
            rd_req  <= 1'b0;
            rd_addr <= 16'd0;
            rd_dly  <= 2'b00;
            tx      <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
`ifdef SCCB_RD_EN
            rd_req <= 1'b0;
            rd_dly <= {rd_dly[0], rd_req};
            if (rd_dly[1]) tx <= rd_data;
`endif
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= DEV;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    DEV, AH, AL, WD: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            sh      <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            // Actions fire on the 8th bit only, so partial bytes leave no trace.
                            if (bit_cnt == 4'd7) begin
                                if (state == AH) ptr[15:8] <= byte_in;
                                if (state == AL) ptr[7:0]  <= byte_in;
                                if (state == WD) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= ptr;
                                    wr_data <= byte_in;
                                    ptr     <= ptr + 16'd1;
                                    if (cmd_cnt != 9'd511) cmd_cnt <= cmd_cnt + 9'd1;
                                end
`ifdef SCCB_RD_EN
                                if (state == DEV && byte_in[7:1] == DEV_ADDR && byte_in[0]) begin
                                    rd_req  <= 1'b1;
                                    rd_addr <= ptr;
                                end
`endif
                            end
                        end else if (hold_fire && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            case (state)
                                DEV: begin
`ifdef SCCB_RD_EN
                                    if (dev_match) begin
`else
                                    if (dev_match && !sh[0]) begin
`endif
                                        sda_oe <= 1'b1;
                                        state  <= DEV_ACK;
                                    end else begin
                                        state  <= IGNORE;
                                    end
                                end
                                AH:      begin sda_oe <= 1'b1; state <= AH_ACK; end
                                AL:      begin sda_oe <= 1'b1; state <= AL_ACK; end
                                default: begin sda_oe <= 1'b1; state <= WD_ACK; end
                            endcase
                        end
                    end
                    DEV_ACK, AH_ACK, AL_ACK, WD_ACK: begin
                        if (hold_fire) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            case (state)
                                DEV_ACK: begin
`ifdef SCCB_RD_EN
                                    if (sh[0]) begin
                                        state   <= RD;
                                        sda_oe  <= ~tx[7];
                                        tx      <= {tx[6:0], 1'b0};
                                        bit_cnt <= 4'd1;
                                    end else begin
                                        state <= AH;
                                    end
`else
                                    state <= AH;
`endif
                                end
                                AH_ACK:  state <= AL;
                                default: state <= WD;
                            endcase
                        end
                    end
`ifdef SCCB_RD_EN
                    RD: begin
                        if (hold_fire) begin
                            if (bit_cnt != 4'd8) begin
                                sda_oe  <= ~tx[7];
                                tx      <= {tx[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= RD_MACK;
                            end
                        end
                    end
                    RD_MACK: begin
                        // bit_cnt==0 marks a master ACK waiting for the next byte slot.
                        if (scl_rise && bit_cnt == 4'd8) begin
                            if (!sda_in) begin
                                ptr     <= ptr + 16'd1;
                                rd_addr <= ptr + 16'd1;
                                rd_req  <= 1'b1;
                                bit_cnt <= 4'd0;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (hold_fire && bit_cnt == 4'd0) begin
                            state   <= RD;
                            sda_oe  <= ~tx[7];
                            tx      <= {tx[6:0], 1'b0};
                            bit_cnt <= 4'd1;
                        end
                    end
`endif
                    IDLE, IGNORE: ;
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sccb_slave_responder.sv
module tb_sccb_slave_responder;
    logic        clk_25M = 1'b0;
    logic        camera_rstn = 1'b0;
    logic        i2c_sclk = 1'b1;
    logic        m_low = 1'b0;
    wire         sdat;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 8'd0;
    logic        busy;
    logic [8:0]  cmd_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state: expected write stream, pointer, write count.
    logic [23:0] exp_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] mptr = 16'd0;
    int          n_wr = 0;
    logic [7:0]  txn[$];
    logic [23:0] mon_e;
    logic [15:0] mon_a;

    pullup (sdat);
    assign sdat = m_low ? 1'b0 : 1'bz;

    always #20 clk_25M = ~clk_25M;

    sccb_slave_responder dut (
        .clk_25M    (clk_25M),
        .camera_rstn(camera_rstn),
        .i2c_sclk   (i2c_sclk),
        .i2c_sdat   (sdat),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .cmd_cnt    (cmd_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Register-file stand-in: data is a fixed function of the requested address.
`ifdef SCCB_RD_EN
    always @(posedge clk_25M) if (rd_req) rd_data <= rd_addr[7:0] ^ 8'h5A;
`endif

    // Monitor: every strobe is matched against the scoreboard.
    always @(negedge clk_25M) begin
        if (camera_rstn && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr_unexpected actual=%0h_%0h required=none", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e[23:8]));
                check("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
            end
        end
        if (camera_rstn && rd_req) begin
`ifdef SCCB_RD_EN
            if (exp_rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_unexpected actual=%0h required=none", rd_addr);
            end else begin
                mon_a = exp_rd_q.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(mon_a));
            end
`else
            check("rd_req_tied", 32'(rd_req), 32'd0);
`endif
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_25M);
    endtask

    // One SCL cycle: entered 10 cycles into SCL low, left at the same point.
    task automatic clk_bit(input logic b, output logic s);
        m_low = ~b;
        wait_clk(10);
        i2c_sclk = 1'b1;
        wait_clk(10);
        s = sdat;
        wait_clk(10);
        i2c_sclk = 1'b0;
        wait_clk(10);
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        wait_clk(10);
        i2c_sclk = 1'b1;
        wait_clk(10);
        m_low = 1'b1;
        wait_clk(10);
        i2c_sclk = 1'b0;
        wait_clk(10);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_clk(10);
        i2c_sclk = 1'b1;
        wait_clk(10);
        m_low = 1'b0;
        wait_clk(20);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        check($sformatf("ack_%02h", b), 32'(s), 32'(ack_exp));
    endtask

    task automatic read_byte(input logic m_ack, input logic [7:0] exp);
        logic s;
        logic [7:0] d;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clk_bit(~m_ack, s);
        check("rd_byte", 32'(d), 32'(exp));
    endtask

    // Full write-style transaction from txn[], optional trailing partial byte.
    task automatic run_txn(input int partial);
        logic dev_ok;
        logic s;
        bus_start();
        check("busy_start", 32'(busy), 32'd1);
        dev_ok = (txn[0] == 8'h78);
        for (int i = 0; i < txn.size(); i++) begin
            if (dev_ok && i == 1) mptr[15:8] = txn[1];
            if (dev_ok && i == 2) mptr[7:0] = txn[2];
            if (dev_ok && i >= 3) begin
                exp_q.push_back({mptr, txn[i]});
                mptr = mptr + 16'd1;
                n_wr++;
            end
            send_byte(txn[i], ~dev_ok);
        end
        for (int i = 0; i < partial; i++) clk_bit(1'($urandom_range(0, 1)), s);
        bus_stop();
        check("busy_stop", 32'(busy), 32'd0);
        check("cmd_cnt", 32'(cmd_cnt), 32'((n_wr > 511) ? 511 : n_wr));
    endtask

    initial begin
        logic s;
        int   r;
        wait_clk(5);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_cmd_cnt", 32'(cmd_cnt), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_sda", 32'(sdat), 32'd1);
        camera_rstn = 1'b1;
        wait_clk(5);

        txn = '{8'h78, 8'h31, 8'h03, 8'h11};               run_txn(0);
        txn = '{8'h42, 8'h30};                             run_txn(0);
        txn = '{8'h78, 8'h58, 8'h00, 8'h23, 8'h14};        run_txn(0);
        txn = '{8'h78, 8'hFF, 8'hFF, 8'hAA, 8'hBB};        run_txn(0);
        txn = '{8'h78, 8'h12, 8'h34, 8'h55};               run_txn(5);

        // Repeated start into a read keeps the loaded pointer.
        bus_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h0A, 1'b0);
        mptr = 16'h300A;
        m_low = 1'b0;
        wait_clk(10);
        i2c_sclk = 1'b1;
        wait_clk(10);
        bus_start();
        check("busy_rstart", 32'(busy), 32'd1);
`ifdef SCCB_RD_EN
        exp_rd_q.push_back(16'h300A);
        exp_rd_q.push_back(16'h300B);
        exp_rd_q.push_back(16'h300C);
        send_byte(8'h79, 1'b0);
        read_byte(1'b1, 8'h0A ^ 8'h5A);
        read_byte(1'b1, 8'h0B ^ 8'h5A);
        read_byte(1'b0, 8'h0C ^ 8'h5A);
        mptr = 16'h300C;
`else
        send_byte(8'h79, 1'b1);
`endif
        bus_stop();
        check("busy_rd_stop", 32'(busy), 32'd0);

        // Randomized transactions against the model.
        for (int t = 0; t < 14; t++) begin
            txn.delete();
            r = $urandom_range(0, 3);
            if (r <= 1) txn.push_back(8'h78);
            else if (r == 2) begin
                txn.push_back(8'($urandom_range(0, 255)));
                if (txn[0][7:1] == 7'h3C) txn[0] = 8'h50;
            end else begin
`ifdef SCCB_RD_EN
                txn.push_back(8'h78);
`else
                txn.push_back(8'h79);
`endif
            end
            for (int k = $urandom_range(0, 5); k > 0; k--) txn.push_back(8'($urandom_range(0, 255)));
            run_txn(($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
        end

        // Reset in the middle of the low address byte.
        bus_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'h12, 1'b0);
        for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
        m_low = 1'b0;
        camera_rstn = 1'b0;
        #1;
        check("mid_rst_sda", 32'(sdat), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_cnt", 32'(cmd_cnt), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        mptr = 16'd0;
        n_wr = 0;
        wait_clk(5);
        camera_rstn = 1'b1;
        wait_clk(2);
        bus_stop();
        txn = '{8'h78, 8'h12, 8'h34, 8'hA5};
        run_txn(0);

        check("wr_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
